uart_rx_duty: RTL and testbench

//  - UART receiver stage directly upstream of the PWM generator: deserialises 8N1 frames from a serial line.
//  - Holds the last good byte on PORT_RX, which drives the PWM duty input (duty = PORT_RX/256).
//  - Reports per-frame status pulses (valid, framing error) and a busy flag.

---
 rtl/uart_rx_duty_pkg.sv | 23 ++
 rtl/uart_rx_duty_sync_2ff.sv | 32 +++
 rtl/uart_rx_duty.sv | 132 +++++++++++++
 tb/tb_uart_rx_duty.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_duty_pkg.sv
// Shared definitions for the duty-word UART receiver: FSM encodings, frame width
// and the bit-timing derivation used by the receiver and its testbench.
package uart_rx_duty_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_duty_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset level is a parameter
// so idle-high lines (UART) come out of reset without a false edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_duty.sv
// 8N1 UART receiver holding the last good byte as the PWM duty word, with
// one-cycle valid / framing-error pulses and a busy flag.
module uart_rx_duty
  import uart_rx_duty_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115_200,
  parameter logic [7:0] RESET_DUTY = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  output logic [7:0] PORT_RX,
  output logic       DATA_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF  = half_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (RX),
    .q     (rx_s)
  );

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                port_q, port_d;
  logic                      dv_q, dv_d;
  logic                      fe_q, fe_d;
  logic                      busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    port_d  = port_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      // Re-check the line at mid start bit; a high here was a glitch.
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            port_d  = shift_q;
            dv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Hold here through a break so it reports a single framing error.
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      port_q  <= RESET_DUTY;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      port_q  <= port_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign PORT_RX    = port_q;
  assign DATA_VALID = dv_q;
  assign FRAME_ERR  = fe_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_duty.sv
// Bench for uart_rx_duty: directed and random 8N1 frames checked against a queue of
// expected frame outcomes (byte or framing error) with start-edge latency.
module tb_uart_rx_duty;

  localparam int         CPB  = 16;
  localparam logic [7:0] RDUT = 8'h00;

  logic       CLK, RST_N, RX;
  logic [7:0] PORT_RX;
  logic       DATA_VALID, FRAME_ERR, BUSY;

  uart_rx_duty #(.CLK_FREQ(1_600_000), .BAUD(100_000), .RESET_DUTY(RDUT)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RX         (RX),
    .PORT_RX    (PORT_RX),
    .DATA_VALID (DATA_VALID),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { bit fe; logic [7:0] d; int t0; } exp_t;
  exp_t       exp_q[$];
  int         dv_times[$];
  logic [7:0] model_port = RDUT;
  int         n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every status pulse must match the oldest outstanding frame; PORT_RX only moves on DV.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (DATA_VALID || FRAME_ERR) begin
        chk("excl", {31'd0, DATA_VALID & FRAME_ERR}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, DATA_VALID, FRAME_ERR}, 32'd0);
        end else begin
          exp_t e;
          int   lat;
          e   = exp_q.pop_front();
          lat = cyc - e.t0;
          chk("kind_fe", {31'd0, FRAME_ERR}, {31'd0, e.fe});
          chk("latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
          if (DATA_VALID) begin
            model_port = e.d;
            dv_times.push_back(cyc);
          end
        end
      end
      chk("port_rx", {24'd0, PORT_RX}, {24'd0, model_port});
    end
  end

  task automatic go(input int off);
    @(posedge CLK);
    #(off);
  endtask

  // Caller is positioned at posedge+off; returns at posedge+off after the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int off);
    exp_t e;
    RX = 1'b0;
    e.fe = !stop_ok; e.d = b; e.t0 = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge CLK);
      #(off);
      RX = b[i];
    end
    repeat (CPB) @(posedge CLK);
    #(off);
    RX = stop_ok;
    repeat (CPB) @(posedge CLK);
    #(off);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RX = 1'b1; RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_port", {24'd0, PORT_RX}, {24'd0, RDUT});
    chk("rst_dv", {31'd0, DATA_VALID}, 32'd0);
    chk("rst_fe", {31'd0, FRAME_ERR}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);

    // 1: single good frame
    go(2);
    send_frame(8'hA5, 1'b1, 2);
    drain(400);
    chk("t1_port", {24'd0, PORT_RX}, 32'hA5);
    chk("t1_busy", {31'd0, BUSY}, 32'd0);

    // 2: short glitch
    go(3);
    RX = 1'b0;
    repeat (4) @(posedge CLK);
    #3 RX = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("t2_busy", {31'd0, BUSY}, 32'd0);
    chk("t2_port", {24'd0, PORT_RX}, 32'hA5);

    // 3: framing error followed by a 40-bit break, then a good frame
    go(2);
    send_frame(8'h3C, 1'b0, 2);
    repeat (39 * CPB) @(posedge CLK);
    #2 RX = 1'b1;
    repeat (3 * CPB) @(posedge CLK);
    drain(10);
    chk("t3_port_held", {24'd0, PORT_RX}, 32'hA5);
    go(2);
    send_frame(8'h01, 1'b1, 2);
    drain(400);
    chk("t3_port", {24'd0, PORT_RX}, 32'h01);

    // 4: back-to-back frames, single stop bit
    dv_times.delete();
    go(4);
    send_frame(8'h00, 1'b1, 4);
    send_frame(8'hFF, 1'b1, 4);
    drain(400);
    chk("t4_count", dv_times.size(), 2);
    if (dv_times.size() == 2) chk("t4_spacing", dv_times[1] - dv_times[0], 160);
    chk("t4_port", {24'd0, PORT_RX}, 32'hFF);

    // Random frames: random bytes, gaps, offsets and occasional bad stop bits
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      bit         ok;
      int         off;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      off = $urandom_range(1, 9);
      repeat ($urandom_range(0, 20)) @(posedge CLK);
      go(off);
      send_frame(b, ok, off);
      if (!ok) begin
        repeat ($urandom_range(0, 3 * CPB)) @(posedge CLK);
        #(off) RX = 1'b1;
        repeat (CPB) @(posedge CLK);
      end
      if ($urandom_range(0, 2) == 0) drain(400);
    end
    drain(400);
    chk("rand_busy", {31'd0, BUSY}, 32'd0);

    // 5: reset in the middle of the data bits
    go(2);
    RX = 1'b0;
    repeat (CPB) @(posedge CLK);
    for (int i = 0; i < 4; i++) begin
      #2 RX = i[0];
      repeat (CPB) @(posedge CLK);
    end
    #2;
    chk("t5_busy_pre", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b0;
    exp_q.delete();
    model_port = RDUT;
    #1;
    chk("t5_port", {24'd0, PORT_RX}, {24'd0, RDUT});
    chk("t5_dv", {31'd0, DATA_VALID}, 32'd0);
    chk("t5_fe", {31'd0, FRAME_ERR}, 32'd0);
    chk("t5_busy", {31'd0, BUSY}, 32'd0);
    RX = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    go(2);
    send_frame(8'h7E, 1'b1, 2);
    drain(400);
    chk("t5_port_after", {24'd0, PORT_RX}, 32'h7E);

    // 6: start-edge phase sweep
    for (int ph = 0; ph < 16; ph++) begin
      repeat (ph) @(posedge CLK);
      go((ph % 9) + 1);
      send_frame(8'h55, 1'b1, (ph % 9) + 1);
      drain(400);
      chk("t6_port", {24'd0, PORT_RX}, 32'h55);
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
